multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
- Main sequencing controller for the multicycle ARM datapath: regfile, extend, mux2/mux3/mux4, flopenr PC/IR, ALU, shifter.
- Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and write enables.
- Applies the condition-check result to architectural writes and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instruction bits [27:26] from IR: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  in  6  IR[25:20]: [5]=I (immediate), [0]=S (data-proc) / L (memory, 1=load).
- Rd  in  4  IR[15:12]; used for PC-destination detection.
- CondEx  in  1  combinational condition-check result for the current instruction.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALU result register.
- ALUSrcA  out  1  0=register A, 1=PC.
- ALUSrcB  out  2  00=register B (after shifter), 01=ExtImm, 10=constant 4.
- ResultSrc  out  2  00=ALUOut, 01=Data register, 10=ALU result.
- ALUOp  out  1  1=decode Funct as a data-processing op; 0=add.
- PCWrite  out  1  PC register enable.
- RegWrite  out  1  regfile we3.
- MemWrite  out  1  data memory write enable.
- FlagWrite  out  1  NZCV flag register enable.
- Retire  out  1  one-cycle pulse in the last cycle of each instruction.
- Undef  out  1  one-cycle pulse when an undefined opcode is decoded.
- RetireCnt  out  CNT_W  count of retired instructions.

Behaviour:
- States, 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Unused encodings 10-15 go to FETCH on the next edge with all enables 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01->MEMADR; Op=00 with I=0->EXECR, with I=1->EXECI; Op=10->BRANCH; Op=11->FETCH with Undef=1 and Retire=1.
  - MEMADR->MEMRD if L=1, else MEMWR.
  - MEMRD->MEMWB->FETCH.
  - MEMWR->FETCH.
  - EXECR/EXECI->ALUWB->FETCH.
  - BRANCH->FETCH.
- Raw Moore outputs per state (unlisted outputs are 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: ResultSrc=00, AdrSrc=1, MemW=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1, FlagW=Funct[0].
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Br=1.
- Condition gating (combinational, same cycle):
  - PCS = (RegW & Rd==15) | Br.
  - PCWrite = NextPC | (PCS & CondEx).
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
  - FlagWrite = FlagW & CondEx.
- Latency: memory load 5 cycles, store 4, data-processing 4, branch 3, undefined 2.
- Condition failure:
  - A failed CondEx does not shorten the instruction; the FSM still walks the full path.
  - Only writes are suppressed.
  - Retire still pulses.
- Retire:
  - Asserted in MEMWB, MEMWR, ALUWB, BRANCH, and in DECODE when Op=11.
  - RetireCnt increments on each edge where Retire=1.
  - RetireCnt wraps from 2^CNT_W-1 to 0.
- Reset (reset=0):
  - State is forced to FETCH and RetireCnt to 0 immediately, asynchronously.
  - While reset is low, IRWrite, PCWrite, RegWrite, MemWrite, FlagWrite, Retire and Undef are forced to 0.
  - While reset is low, the selects hold their FETCH values.
  - Reset asserted mid-instruction aborts it with no further writes and no Retire.
  - The first FETCH enables assert in the cycle after reset deasserts.
- Op, Funct and Rd are sampled combinationally; the IR holds them stable from DECODE onward.

Decomposition:
- Shared package ctrl_pkg:
  - state enum statetype_t with the encodings above.
  - Constants for the ALUSrcB and ResultSrc encodings.
  - Op codes OP_DP=00, OP_MEM=01, OP_BR=10.
- Sub-module cond_gate: the purely combinational PCS/CondEx gating. The FSM core holds the state register, next-state logic, output decode and counter.

Test Plan:
- LDR (Op=01, Funct=011001, CondEx=1) -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB; PCWrite=1 only in FETCH; RetireCnt 0->1.
- STR with CondEx=0 -> path 0,1,2,5,0; MemWrite stays 0; Retire pulses once in MEMWR.
- ADDS immediate (Op=00, Funct=101001, Rd=15, CondEx=1) -> EXECI then ALUWB; RegWrite, FlagWrite and PCWrite all 1 in ALUWB.
- B (Op=10, CondEx=0) -> 0,1,9,0; PCWrite=0 in BRANCH; then repeat with CondEx=1 -> PCWrite=1 in BRANCH.
- Op=11 -> Undef=1 and Retire=1 in DECODE; next state FETCH; no write enable asserted.
- Assert reset low during MEMRD -> all enables drop at once; state=FETCH and RetireCnt=0 without a clock edge. Separately, with CNT_W=4, retire 16 instructions -> counter wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } statetype_t;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_cond_gate.sv
// Condition gating: qualifies raw Moore write strobes with CondEx and the run enable.
module cond_gate (
  input  logic       i_en,
  input  logic       i_next_pc,
  input  logic       i_reg_w,
  input  logic       i_mem_w,
  input  logic       i_flag_w,
  input  logic       i_br,
  input  logic [3:0] i_rd,
  input  logic       i_cond_ex,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic       o_mem_write,
  output logic       o_flag_write
);

  logic w_pcs;

  // A register write to R15 is a PC write and must obey the condition like a branch.
  assign w_pcs        = (i_reg_w & (i_rd == 4'd15)) | i_br;
  assign o_pc_write   = i_en & (i_next_pc | (w_pcs & i_cond_ex));
  assign o_reg_write  = i_en & i_reg_w & i_cond_ex;
  assign o_mem_write  = i_en & i_mem_w & i_cond_ex;
  assign o_flag_write = i_en & i_flag_w & i_cond_ex;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM main controller: Moore FSM, output decode and retired-instruction counter.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic             CondEx,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             FlagWrite,
  output logic             Retire,
  output logic             Undef,
  output logic [CNT_W-1:0] RetireCnt
);

  // state  | meaning
  // FETCH  | read instruction at PC, PC <= PC+4
  // DECODE | read registers, dispatch on Op
  // MEMADR | compute load/store address
  // MEMRD  | read data memory
  // MEMWB  | write loaded data to Rd
  // MEMWR  | write data memory
  // EXECR  | ALU op with register operand
  // EXECI  | ALU op with immediate operand
  // ALUWB  | write ALU result (and flags if S)
  // BRANCH | PC <= PC+8+offset

  statetype_t       r_state;
  statetype_t       w_next;
  logic             w_irwrite, w_next_pc, w_reg_w, w_mem_w, w_flag_w, w_br;
  logic             w_retire, w_undef;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             w_unused_funct;

  assign w_unused_funct = ^Funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = FETCH;
    w_irwrite = 1'b0;
    w_next_pc = 1'b0;
    w_reg_w   = 1'b0;
    w_mem_w   = 1'b0;
    w_flag_w  = 1'b0;
    w_br      = 1'b0;
    w_retire  = 1'b0;
    w_undef   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    ALUOp     = 1'b0;
    case (r_state)
      FETCH: begin
        w_next    = DECODE;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        w_irwrite = 1'b1;
        w_next_pc = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        case (Op)
          OP_MEM:  w_next = MEMADR;
          OP_DP:   w_next = Funct[5] ? EXECI : EXECR;
          OP_BR:   w_next = BRANCH;
          default: begin
            w_next   = FETCH;
            w_undef  = 1'b1;
            w_retire = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        w_next  = Funct[0] ? MEMRD : MEMWR;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        w_next = MEMWB;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        w_reg_w   = 1'b1;
        w_retire  = 1'b1;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        w_mem_w  = 1'b1;
        w_retire = 1'b1;
      end
      EXECR: begin
        w_next = ALUWB;
        ALUOp  = 1'b1;
      end
      EXECI: begin
        w_next  = ALUWB;
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        w_reg_w  = 1'b1;
        w_flag_w = Funct[0];
        w_retire = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        w_br      = 1'b1;
        w_retire  = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  cond_gate u_cond_gate (
    .i_en        (reset),
    .i_next_pc   (w_next_pc),
    .i_reg_w     (w_reg_w),
    .i_mem_w     (w_mem_w),
    .i_flag_w    (w_flag_w),
    .i_br        (w_br),
    .i_rd        (Rd),
    .i_cond_ex   (CondEx),
    .o_pc_write  (PCWrite),
    .o_reg_write (RegWrite),
    .o_mem_write (MemWrite),
    .o_flag_write(FlagWrite)
  );

  // Strobes are masked by reset so an aborted instruction produces nothing.
  assign IRWrite = w_irwrite & reset;
  assign Retire  = w_retire & reset;
  assign Undef   = w_undef & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_retire_cnt <= '0;
    else if (Retire) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
  end

  assign RetireCnt = r_retire_cnt;

endmodule
